// File: rtl/bank_group_scheduler_if.sv
// Request and datapath-command bundle between the channel decoder and one bank-group scheduler.
interface bank_group_scheduler_if #(
  parameter int BAWIDTH   = 2,
  parameter int ADDRWIDTH = 17,
  parameter int COLWIDTH  = 10
);
  localparam int BANKSPERGROUP = 2 ** BAWIDTH;

  logic                     req_valid;
  logic                     req_ready;
  logic [BAWIDTH-1:0]       req_bank;
  logic [ADDRWIDTH-1:0]     req_row;
  logic [COLWIDTH-1:0]      req_col;
  logic                     req_wr;
  logic                     ref_req;
  logic                     ref_ack;
  logic                     rd_o_wr [BANKSPERGROUP-1:0];
  logic [ADDRWIDTH-1:0]     row     [BANKSPERGROUP-1:0];
  logic [COLWIDTH-1:0]      column  [BANKSPERGROUP-1:0];
  logic                     beat_valid;
  logic [BAWIDTH-1:0]       beat_bank;
  logic                     beat_last;
  logic [BANKSPERGROUP-1:0] open_mask;

  modport slave (
    input  req_valid, req_bank, req_row, req_col, req_wr, ref_req,
    output req_ready, ref_ack, rd_o_wr, row, column,
           beat_valid, beat_bank, beat_last, open_mask
  );

  modport master (
    output req_valid, req_bank, req_row, req_col, req_wr, ref_req,
    input  req_ready, ref_ack, rd_o_wr, row, column,
           beat_valid, beat_bank, beat_last, open_mask
  );
endinterface

// File: rtl/bank_group_scheduler.sv
// Open-page command sequencer for one DDR bank group: precharge/activate phases,
// then BL wrapped column beats to the addressed bank; precharge-all on ref_req.
module bank_group_scheduler #(
  parameter int BAWIDTH   = 2,
  parameter int ADDRWIDTH = 17,
  parameter int COLWIDTH  = 10,
  parameter int BL        = 8,
  parameter int TRP       = 4,
  parameter int TRCD      = 4
) (
  input logic                   clk,
  input logic                   rst,
  bank_group_scheduler_if.slave bus
);
  localparam int BANKS = 2 ** BAWIDTH;
  localparam int MAXTR = (TRP > TRCD) ? TRP : TRCD;
  localparam int MAXPH = (MAXTR > BL) ? MAXTR : BL;
  localparam int CNTW  = $clog2(MAXPH + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PRE    = 3'd1;
  localparam logic [2:0] S_ACT    = 3'd2;
  localparam logic [2:0] S_BURST  = 3'd3;
  localparam logic [2:0] S_PREALL = 3'd4;

  logic [2:0]           r_state;
  logic [CNTW-1:0]      r_cnt;
  logic                 r_ready;
  logic [BAWIDTH-1:0]   r_bank;
  logic [ADDRWIDTH-1:0] r_row_lat;
  logic [COLWIDTH-1:0]  r_col_lat;
  logic                 r_wr;
  logic [BANKS-1:0]     r_open;
  logic [ADDRWIDTH-1:0] r_orow [BANKS];
  logic [COLWIDTH-1:0]  r_colv [BANKS];
  logic                 r_rdwr [BANKS];
  logic                 r_beat_valid;
  logic                 r_beat_last;
  logic                 r_ref_ack;
  logic [BAWIDTH-1:0]   r_beat_bank;

  logic [2:0]           w_state_nxt;
  logic [CNTW-1:0]      w_cnt_nxt;
  logic [BAWIDTH-1:0]   w_bank_nxt;
  logic [ADDRWIDTH-1:0] w_row_nxt;
  logic [COLWIDTH-1:0]  w_col_nxt;
  logic                 w_wr_nxt;
  logic                 w_hit;
  logic                 w_emit;
  logic                 w_last;
  logic [COLWIDTH-1:0]  w_k;
  logic [COLWIDTH-1:0]  w_col_out;
  logic                 w_clr_one;
  logic                 w_set_one;
  logic                 w_clr_all;
  logic                 w_ack;

  // Beats wrap inside the BL-aligned column block; the upper column bits never change.
  function automatic logic [COLWIDTH-1:0] wrap_col(input logic [COLWIDTH-1:0] base,
                                                   input logic [COLWIDTH-1:0] k);
    logic [COLWIDTH-1:0] mask;
    mask     = COLWIDTH'(BL - 1);
    wrap_col = (base & ~mask) | ((base + k) & mask);
  endfunction

  assign w_hit = r_open[bus.req_bank] && (r_orow[bus.req_bank] == bus.req_row);

  // Next-state decode; a beat is registered on the same edge that enters or advances BURST
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bank_nxt  = r_bank;
    w_row_nxt   = r_row_lat;
    w_col_nxt   = r_col_lat;
    w_wr_nxt    = r_wr;
    w_emit      = 1'b0;
    w_k         = '0;
    w_clr_one   = 1'b0;
    w_set_one   = 1'b0;
    w_clr_all   = 1'b0;
    w_ack       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_ready && bus.ref_req) begin
          w_state_nxt = S_PREALL;
          w_cnt_nxt   = CNTW'(TRP);
          w_clr_all   = 1'b1;
          w_ack       = (TRP == 1) ? 1'b1 : 1'b0;
        end else if (r_ready && bus.req_valid) begin
          w_bank_nxt = bus.req_bank;
          w_row_nxt  = bus.req_row;
          w_col_nxt  = bus.req_col;
          w_wr_nxt   = bus.req_wr;
          if (w_hit) begin
            w_state_nxt = S_BURST;
            w_cnt_nxt   = CNTW'(BL);
            w_emit      = 1'b1;
          end else if (r_open[bus.req_bank]) begin
            w_state_nxt = S_PRE;
            w_cnt_nxt   = CNTW'(TRP);
            w_clr_one   = 1'b1;
          end else begin
            w_state_nxt = S_ACT;
            w_cnt_nxt   = CNTW'(TRCD);
            w_set_one   = 1'b1;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_PRE: begin
        if (r_cnt == CNTW'(1)) begin
          w_state_nxt = S_ACT;
          w_cnt_nxt   = CNTW'(TRCD);
          w_set_one   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CNTW'(1);
        end
      end
      S_ACT: begin
        if (r_cnt == CNTW'(1)) begin
          w_state_nxt = S_BURST;
          w_cnt_nxt   = CNTW'(BL);
          w_emit      = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CNTW'(1);
        end
      end
      S_BURST: begin
        if (r_cnt == CNTW'(1)) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - CNTW'(1);
          w_emit    = 1'b1;
          w_k       = COLWIDTH'(CNTW'(BL) - r_cnt + CNTW'(1));
        end
      end
      S_PREALL: begin
        if (r_cnt == CNTW'(1)) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - CNTW'(1);
          w_ack     = (r_cnt == CNTW'(2)) ? 1'b1 : 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
    w_col_out = wrap_col(w_col_nxt, w_k);
    w_last    = w_emit && (w_k == COLWIDTH'(BL - 1));
  end

  // FSM, request latch, per-bank open state and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_ready      <= 1'b0;
      r_bank       <= '0;
      r_row_lat    <= '0;
      r_col_lat    <= '0;
      r_wr         <= 1'b0;
      r_open       <= '0;
      r_beat_valid <= 1'b0;
      r_beat_last  <= 1'b0;
      r_ref_ack    <= 1'b0;
      r_beat_bank  <= '0;
      for (int b = 0; b < BANKS; b++) begin
        r_orow[b] <= '0;
        r_colv[b] <= '0;
        r_rdwr[b] <= 1'b0;
      end
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_ready      <= (w_state_nxt == S_IDLE);
      r_bank       <= w_bank_nxt;
      r_row_lat    <= w_row_nxt;
      r_col_lat    <= w_col_nxt;
      r_wr         <= w_wr_nxt;
      r_beat_valid <= w_emit;
      r_beat_last  <= w_last;
      r_ref_ack    <= w_ack;
      if (w_clr_all) begin
        r_open <= '0;
      end else if (w_clr_one) begin
        r_open[w_bank_nxt] <= 1'b0;
      end else if (w_set_one) begin
        r_open[w_bank_nxt] <= 1'b1;
        r_orow[w_bank_nxt] <= w_row_nxt;
      end
      if (w_emit) begin
        r_beat_bank        <= w_bank_nxt;
        r_colv[w_bank_nxt] <= w_col_out;
      end
      for (int b = 0; b < BANKS; b++) begin
        r_rdwr[b] <= w_emit & w_wr_nxt & (w_bank_nxt == BAWIDTH'(b));
      end
    end
  end

  // req_ready drops combinationally under ref_req so refresh always wins in IDLE
  assign bus.req_ready  = r_ready & ~bus.ref_req;
  assign bus.ref_ack    = r_ref_ack;
  assign bus.beat_valid = r_beat_valid;
  assign bus.beat_bank  = r_beat_bank;
  assign bus.beat_last  = r_beat_last;
  assign bus.open_mask  = r_open;

  for (genvar g = 0; g < BANKS; g++) begin : g_bank
    assign bus.rd_o_wr[g] = r_rdwr[g];
    assign bus.row[g]     = r_orow[g];
    assign bus.column[g]  = r_colv[g];
  end
endmodule

// File: tb/tb_bank_group_scheduler.sv
// Self-checking bench for bank_group_scheduler: directed vector table, refresh/reset
// sequences and randomized traffic against a bank-state reference model.
module tb_bank_group_scheduler;
  localparam int BAW  = 2;
  localparam int AW   = 17;
  localparam int CW   = 10;
  localparam int BL   = 8;
  localparam int TRP  = 4;
  localparam int TRCD = 4;
  localparam int NB   = 4;

  typedef struct {
    int bank;
    int row;
    int col;
    bit wr;
    int lat;
    int fcol;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   m_open [NB];
  int   m_row  [NB];
  logic [NB-1:0] rdwr_p;
  vec_t tv [10];

  always #5 clk = ~clk;

  bank_group_scheduler_if #(.BAWIDTH(BAW), .ADDRWIDTH(AW), .COLWIDTH(CW)) bus ();

  bank_group_scheduler #(
    .BAWIDTH(BAW), .ADDRWIDTH(AW), .COLWIDTH(CW), .BL(BL), .TRP(TRP), .TRCD(TRCD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always_comb begin
    rdwr_p = '0;
    for (int i = 0; i < NB; i++) rdwr_p[i] = bus.rd_o_wr[i];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int exp_col(input int col, input int k);
    int base;
    base = col - (col % BL);
    return base + ((col % BL + k) % BL);
  endfunction

  function automatic int exp_mask();
    int m;
    m = 0;
    for (int i = 0; i < NB; i++) if (m_open[i]) m += (1 << i);
    return m;
  endfunction

  task automatic wait_ready(output bit ok);
    int guard;
    guard = 0;
    while (bus.req_ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    ok = (bus.req_ready === 1'b1);
    chk("ready_wait", 32'(bus.req_ready), 32'd1);
  endtask

  task automatic scramble();
    bus.req_bank = BAW'($urandom);
    bus.req_row  = AW'($urandom);
    bus.req_col  = CW'($urandom);
    bus.req_wr   = 1'($urandom);
  endtask

  // Issue one request and check every cycle up to req_ready returning.
  task automatic run_req(input int bank, input int rw, input int cl, input bit wr,
                         output int first, output int fcol);
    bit ok, hit, miss, bv;
    int lat, k;
    first = 0;
    fcol  = -1;
    wait_ready(ok);
    if (!ok) return;
    hit  = m_open[bank] && (m_row[bank] == rw);
    miss = m_open[bank] && !hit;
    lat  = hit ? 1 : (miss ? 1 + TRP + TRCD : 1 + TRCD);
    bus.req_valid = 1'b1;
    bus.req_bank  = BAW'(bank);
    bus.req_row   = AW'(rw);
    bus.req_col   = CW'(cl);
    bus.req_wr    = wr;
    @(negedge clk);
    bus.req_valid = 1'b0;
    scramble();
    m_open[bank] = 1'b1;
    m_row[bank]  = rw;
    for (int c = 1; c <= lat + BL; c++) begin
      if (c > 1) @(negedge clk);
      bv = (c >= lat) && (c < lat + BL);
      chk("beat_valid", 32'(bus.beat_valid), 32'(bv));
      if (bus.beat_valid === 1'b1 && first == 0) begin
        first = c;
        fcol  = int'(bus.column[bank]);
      end
      if (bv) begin
        k = c - lat;
        chk("column", 32'(bus.column[bank]), 32'(exp_col(cl, k)));
        chk("beat_bank", 32'(bus.beat_bank), 32'(bank));
        chk("beat_last", 32'(bus.beat_last), 32'(k == BL - 1));
        chk("rd_o_wr", 32'(rdwr_p), wr ? 32'(1 << bank) : 32'd0);
        chk("row", 32'(bus.row[bank]), 32'(rw));
      end else if (c < lat) begin
        chk("open_bit", 32'(bus.open_mask[bank]), (miss && c <= TRP) ? 32'd0 : 32'd1);
        chk("rd_o_wr_idle", 32'(rdwr_p), 32'd0);
      end
      chk("req_ready", 32'(bus.req_ready), 32'(c == lat + BL));
    end
    chk("open_mask", 32'(bus.open_mask), 32'(exp_mask()));
  endtask

  // Precharge-all, optionally with a competing request presented in the same cycle.
  task automatic do_ref(input bit with_req);
    bit ok;
    wait_ready(ok);
    if (!ok) return;
    bus.ref_req = 1'b1;
    if (with_req) begin
      bus.req_valid = 1'b1;
      bus.req_bank  = BAW'(1);
      bus.req_row   = AW'(m_row[1]);
      bus.req_col   = CW'(0);
      bus.req_wr    = 1'b1;
    end
    #1;
    chk("ready_under_ref", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    bus.ref_req   = 1'b0;
    bus.req_valid = 1'b0;
    for (int i = 0; i < NB; i++) m_open[i] = 1'b0;
    for (int c = 1; c <= TRP + 1; c++) begin
      if (c > 1) @(negedge clk);
      chk("ref_ack", 32'(bus.ref_ack), 32'(c == TRP));
      chk("open_mask_ref", 32'(bus.open_mask), 32'd0);
      chk("beat_valid_ref", 32'(bus.beat_valid), 32'd0);
      chk("ready_ref", 32'(bus.req_ready), 32'(c == TRP + 1));
    end
  endtask

  task automatic check_all_zero(input string nm);
    for (int i = 0; i < NB; i++) begin
      chk({nm, "_row"}, 32'(bus.row[i]), 32'd0);
      chk({nm, "_col"}, 32'(bus.column[i]), 32'd0);
    end
    chk({nm, "_rdwr"}, 32'(rdwr_p), 32'd0);
    chk({nm, "_beat_valid"}, 32'(bus.beat_valid), 32'd0);
    chk({nm, "_open"}, 32'(bus.open_mask), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, fcol, nbeat, guard, bank, rw;
    bit ok;
    tv[0] = '{2, 'h155,   'h3F8, 1'b0, 5, 'h3F8};
    tv[1] = '{2, 'h155,   'h3FD, 1'b1, 1, 'h3FD};
    tv[2] = '{2, 'h001,   'h010, 1'b0, 9, 'h010};
    tv[3] = '{0, 'h0AA,   'h123, 1'b1, 5, 'h123};
    tv[4] = '{1, 'h1234,  'h007, 1'b0, 5, 'h007};
    tv[5] = '{3, 'h1FFFF, 'h3FF, 1'b1, 5, 'h3FF};
    tv[6] = '{0, 'h0AA,   'h005, 1'b0, 1, 'h005};
    tv[7] = '{1, 'h1234,  'h20E, 1'b1, 1, 'h20E};
    tv[8] = '{2, 'h001,   'h3F9, 1'b0, 1, 'h3F9};
    tv[9] = '{3, 'h1FFFF, 'h000, 1'b1, 1, 'h000};
    for (int i = 0; i < NB; i++) begin
      m_open[i] = 1'b0;
      m_row[i]  = 0;
    end
    bus.req_valid = 1'b0;
    bus.ref_req   = 1'b0;
    scramble();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_ref_ack", 32'(bus.ref_ack), 32'd0);
    chk("rst_beat_bank", 32'(bus.beat_bank), 32'd0);
    chk("rst_beat_last", 32'(bus.beat_last), 32'd0);
    check_all_zero("rst");
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(bus.req_ready), 32'd1);

    // Directed vectors: closed, hit with wrap, miss, then back-to-back hits on every bank
    for (int i = 0; i < 10; i++) begin
      run_req(tv[i].bank, tv[i].row, tv[i].col, tv[i].wr, first, fcol);
      chk("vec_first_beat", 32'(first), 32'(tv[i].lat));
      chk("vec_first_col", 32'(fcol), 32'(tv[i].fcol));
    end

    do_ref(1'b1);
    run_req(1, 'h1234, 'h040, 1'b0, first, fcol);
    chk("after_ref_first_beat", 32'(first), 32'(1 + TRCD));

    // Synchronous reset during beat 3 of a hit burst
    wait_ready(ok);
    if (ok) begin
      bus.req_valid = 1'b1;
      bus.req_bank  = BAW'(1);
      bus.req_row   = AW'('h1234);
      bus.req_col   = CW'(0);
      bus.req_wr    = 1'b1;
      @(negedge clk);
      bus.req_valid = 1'b0;
      nbeat = 0;
      guard = 0;
      while (guard < 50) begin
        if (bus.beat_valid === 1'b1) nbeat++;
        if (nbeat == 4) break;
        @(negedge clk);
        guard++;
      end
      chk("beat3_reached", 32'(nbeat), 32'd4);
      chk("beat3_col", 32'(bus.column[1]), 32'd3);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_ready", 32'(bus.req_ready), 32'd0);
      check_all_zero("midrst");
      rst = 1'b0;
      for (int i = 0; i < NB; i++) m_open[i] = 1'b0;
      @(negedge clk);
      chk("midrst_beat_valid", 32'(bus.beat_valid), 32'd0);
      chk("midrst_ready_back", 32'(bus.req_ready), 32'd1);
    end

    // Randomized traffic over a small row set so hits, misses and closed banks all occur
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        do_ref(1'($urandom));
      end else begin
        bank = int'($urandom_range(0, NB - 1));
        rw   = int'($urandom_range(0, 2)) * 'h155;
        run_req(bank, rw, int'($urandom_range(0, 1023)), 1'($urandom), first, fcol);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/bank_group_scheduler.md
# bank_group_scheduler

Command sequencer for one DDR bank group in the DRAM emulation fabric. It accepts one read/write burst request at a time, tracks the open row of each bank in the group, issues precharge/activate phases with programmable delays, then streams BL column beats to the addressed bank. It drives the per-bank `rd_o_wr`/`row`/`column` vectors of the bank-group datapath and sits between the channel-level command decoder and that datapath.

## Interface
- BAWIDTH, 2: bank address width; BANKSPERGROUP = 2**BAWIDTH.
- ADDRWIDTH, 17: row address width.
- COLWIDTH, 10: column address width.
- BL, 8: burst length in beats; power of two, 2..2**COLWIDTH.
- TRP, 4: precharge phase length in cycles, >= 1.
- TRCD, 4: activate-to-column phase length in cycles, >= 1.
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  scheduler can accept a request this cycle.
- req_bank  in  BAWIDTH  target bank.
- req_row  in  ADDRWIDTH  target row.
- req_col  in  COLWIDTH  starting column.
- req_wr  in  1  1 = write burst, 0 = read burst.
- ref_req  in  1  close all banks (precharge-all) request.
- ref_ack  out  1  one-cycle pulse when precharge-all completes.
- rd_o_wr  out  1 per bank (unpacked [BANKSPERGROUP-1:0])  per-bank write strobe.
- row  out  ADDRWIDTH per bank  per-bank row address.
- column  out  COLWIDTH per bank  per-bank column address.
- beat_valid  out  1  a burst beat is on the datapath this cycle.
- beat_bank  out  BAWIDTH  bank carrying the current beat.
- beat_last  out  1  current beat is the final beat of the burst.
- open_mask  out  BANKSPERGROUP  bit b = 1 when bank b has an open row.

## Operation
- Main FSM states: IDLE, PRE, ACT, BURST, PREALL.
- Per-bank state: open bit plus an open-row register.
- IDLE:
  - `req_ready` = 1 only in IDLE, and not while `ref_req` = 1.
  - `ref_req` = 1 in IDLE -> PREALL. Refresh wins over a simultaneous `req_valid`; the request is not accepted.
  - Otherwise, `req_valid && req_ready` latches bank/row/col/wr and classifies the access:
    - row hit (bank open, same row) -> BURST;
    - bank closed -> ACT;
    - row miss (bank open, different row) -> PRE.
- PRE: runs TRP cycles; clears the target bank's open bit on entry; then -> ACT.
- ACT: runs TRCD cycles; on entry sets the open bit and loads the open-row register with the latched row; then -> BURST.
- BURST: runs BL cycles with beat counter k = 0..BL-1.
  - Column = latched col with low log2(BL) bits replaced by (col_low + k) mod BL, i.e. wrap within the BL-aligned block. Upper bits unchanged.
  - After beat BL-1 -> IDLE.
- Page policy is open-page: rows stay open after a burst.
- PREALL: runs TRP cycles; clears all open bits on entry; pulses `ref_ack` on its last cycle; then -> IDLE.
- Output driving:
  - `row[b]` always equals bank b's open-row register.
  - `column[b]` holds its last value, except the target bank's entry, which updates during BURST.
  - `rd_o_wr[b]` = latched wr only for the target bank during BURST; 0 otherwise.
- `req_*` inputs are ignored outside IDLE and need not stay stable after acceptance.

## Timing
- All outputs are registered.
- Reset values:
  - all open bits 0; all `row`/`column` = 0; `rd_o_wr` all 0;
  - `beat_valid`/`beat_last`/`ref_ack` = 0; `beat_bank` = 0;
  - FSM = IDLE; `req_ready` = 0 during reset and 1 from the first cycle after reset deasserts.
- Cycle numbering below: acceptance edge = cycle 0.
- Latency to first beat:
  - hit: `beat_valid` high cycles 1..BL;
  - closed bank: 1+TRCD;
  - miss: 1+TRP+TRCD.
- `beat_last` coincides with the final beat. `req_ready` returns high the cycle after `beat_last`.
- Back-to-back hits: next request accepted the cycle after `beat_last`; its first beat follows one cycle later (1-cycle bubble).
- Reset mid-operation: the FSM aborts immediately, all state returns to reset values, and no further beats are issued.
- Phase counters are $clog2(max(TRP,TRCD,BL)+1) bits; they count down to 1 and never wrap.

## Test plan
- Reset then closed-bank read bank 2 row 0x155 col 0x3F8, TRCD=4, BL=8 -> beats at cycles 5..12, columns 0x3F8..0x3FF, `row[2]`=0x155, `open_mask`=0100, `rd_o_wr` all 0.
- Row hit write bank 2 row 0x155 col 0x3FD -> beats cycles 1..8, columns 0x3FD,0x3FE,0x3FF,0x3F8..0x3FC (wrap), `rd_o_wr[2]`=1 only during the beats.
- Row miss bank 2 row 0x001, TRP=4, TRCD=4 -> first beat cycle 9, `row[2]`=0x001, open bit low during PRE.
- `ref_req` and `req_valid` asserted together in IDLE -> request not accepted; `ref_ack` pulse after TRP cycles; `open_mask`=0; request accepted the next cycle as closed-bank.
- `rst` asserted at beat 3 of a burst -> next cycle `beat_valid`=0, `open_mask`=0, `req_ready`=0, all row/column 0.
- Four back-to-back hits to different open banks -> each first beat is exactly 2 cycles after the previous `beat_last`, and `beat_bank` tracks the request.
